// File: rtl/timekeeper_core.sv
// timekeeper_core: binary + BCD time-of-day counter advanced by a 1 Hz clock, 12h or 24h.
// Latency: every output is registered, so a load or count appears on the edge that samples it.
// Backpressure: none; priority is reset > load > run > hold. Optional alarm when TIMEKEEPER_ALARM_EN is defined.
module timekeeper_core #(
  parameter int HOUR_MODE = 12
) (
  input  logic        oneSecClk,
  input  logic        reset,
  input  logic        run,
  input  logic        load,
  input  logic [4:0]  load_hour,
  input  logic [5:0]  load_min,
  input  logic [5:0]  load_sec,
  input  logic        load_pm,
`ifdef TIMEKEEPER_ALARM_EN
  input  logic [4:0]  alarm_hour,
  input  logic [5:0]  alarm_min,
  input  logic        alarm_pm,
  input  logic        alarm_ack,
  output logic        alarm,
`endif
  output logic [4:0]  hour,
  output logic [5:0]  min,
  output logic [5:0]  sec,
  output logic        pm,
  output logic [23:0] bcd,
  output logic        min_tick,
  output logic        hour_tick,
  output logic        day_tick,
  output logic        load_err
);

  // Any HOUR_MODE other than 12 counts as 24-hour mode.
  localparam logic       IS_12H   = (HOUR_MODE == 12);
  localparam logic [4:0] HOUR_RST = IS_12H ? 5'd12 : 5'd0;

  logic [4:0]  hour_q, hour_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic        pm_q, pm_d;
  logic [23:0] bcd_q, bcd_d;
  logic        min_tick_q, min_tick_d;
  logic        hour_tick_q, hour_tick_d;
  logic        day_tick_q, day_tick_d;
  logic        load_err_q, load_err_d;
  logic        hour_ok, load_ok;

  // Binary 0..59 to two BCD digits, using a compare chain instead of a divider.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    if (v >= 6'd50) begin
      tens = 4'd5;
      ones = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      tens = 4'd4;
      ones = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      tens = 4'd3;
      ones = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      tens = 4'd2;
      ones = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      tens = 4'd1;
      ones = 4'(v - 6'd10);
    end else begin
      tens = 4'd0;
      ones = v[3:0];
    end
    return {tens, ones};
  endfunction

  // Range-check the load fields; the hour range depends on the counting mode.
  always_comb begin
    hour_ok = IS_12H ? ((load_hour >= 5'd1) && (load_hour <= 5'd12))
                     : (load_hour <= 5'd23);
    load_ok = hour_ok && (load_min <= 6'd59) && (load_sec <= 6'd59);
  end

  // Next-state: load wins over run; counting ripples sec -> min -> hour with tick pulses.
  always_comb begin
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    pm_d        = pm_q;
    min_tick_d  = 1'b0;
    hour_tick_d = 1'b0;
    day_tick_d  = 1'b0;
    load_err_d  = 1'b0;
    if (load) begin
      if (load_ok) begin
        hour_d = load_hour;
        min_d  = load_min;
        sec_d  = load_sec;
        pm_d   = load_pm;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (run) begin
      if (sec_q == 6'd59) begin
        sec_d      = 6'd0;
        min_tick_d = 1'b1;
        if (min_q == 6'd59) begin
          min_d       = 6'd0;
          hour_tick_d = 1'b1;
          if (IS_12H) begin
            if (hour_q == 5'd12) begin
              // 12 -> 1 keeps the AM/PM half.
              hour_d = 5'd1;
            end else begin
              hour_d = hour_q + 5'd1;
              if (hour_q == 5'd11) begin
                // 11 -> 12 crosses noon or midnight; only PM -> AM ends the day.
                pm_d       = ~pm_q;
                day_tick_d = pm_q;
              end
            end
          end else begin
            if (hour_q == 5'd23) begin
              hour_d     = 5'd0;
              day_tick_d = 1'b1;
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
    // In 24h mode pm is purely a function of the hour, whatever load_pm said.
    if (!IS_12H) begin
      pm_d = (hour_d >= 5'd12);
    end
  end

  // BCD is derived from the next binary time so both update on the same edge.
  always_comb begin
    bcd_d = {to_bcd({1'b0, hour_d}), to_bcd(min_d), to_bcd(sec_d)};
  end

  // Time and pulse registers with synchronous active-low reset.
  always_ff @(posedge oneSecClk) begin
    if (!reset) begin
      hour_q      <= HOUR_RST;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      pm_q        <= 1'b0;
      bcd_q       <= {to_bcd({1'b0, HOUR_RST}), 16'h0000};
      min_tick_q  <= 1'b0;
      hour_tick_q <= 1'b0;
      day_tick_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      pm_q        <= pm_d;
      bcd_q       <= bcd_d;
      min_tick_q  <= min_tick_d;
      hour_tick_q <= hour_tick_d;
      day_tick_q  <= day_tick_d;
      load_err_q  <= load_err_d;
    end
  end

  assign hour      = hour_q;
  assign min       = min_q;
  assign sec       = sec_q;
  assign pm        = pm_q;
  assign bcd       = bcd_q;
  assign min_tick  = min_tick_q;
  assign hour_tick = hour_tick_q;
  assign day_tick  = day_tick_q;
  assign load_err  = load_err_q;

`ifdef TIMEKEEPER_ALARM_EN
  logic alarm_q, alarm_d;
  logic alarm_ok, alarm_hit;

  // Alarm fires only on a counting edge landing exactly on hh:mm:00 of a legal alarm time.
  always_comb begin
    alarm_ok  = (IS_12H ? ((alarm_hour >= 5'd1) && (alarm_hour <= 5'd12))
                        : (alarm_hour <= 5'd23)) && (alarm_min <= 6'd59);
    alarm_hit = !load && run && alarm_ok &&
                (hour_d == alarm_hour) && (min_d == alarm_min) && (sec_d == 6'd0) &&
                (!IS_12H || (pm_d == alarm_pm));
    alarm_d   = alarm_hit ? 1'b1 : (alarm_ack ? 1'b0 : alarm_q);
  end

  // Sticky alarm flag; a new hit beats a simultaneous acknowledge.
  always_ff @(posedge oneSecClk) begin
    if (!reset) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`endif

endmodule
